// File: rtl/mem_bus_sequencer_if.sv
// Memory bus between the access sequencer (master) and the memory (slave).
// Signals:
//   mem_valid  master -> slave  request valid, held until mem_ready
//   mem_we     master -> slave  1 = write, 0 = read
//   mem_addr   master -> slave  byte/word address (AW bits)
//   mem_wdata  master -> slave  write data (DW bits)
//   mem_ready  slave -> master  transfer completes this cycle
//   mem_rdata  slave -> master  read data, valid with mem_valid & mem_ready & !mem_we
interface mem_bus_sequencer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Memory-access sequencer sitting in front of the MDR/IR registers.
// Takes one read/write request from the control FSM, runs it on a valid/ready
// memory bus and returns registered read data plus a one-cycle load strobe
// for either MDR (data load) or IR (instruction fetch).
//
// Optional feature: define MEM_TIMEOUT_EN to abort a bus request that sees no
// mem_ready within TIMEOUT+1 cycles; the abort raises the sticky err flag.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-high reset
//   req_valid_i     request from control FSM
//   req_we_i        1 = write, 0 = read
//   req_is_fetch_i  read target: 1 = IR, 0 = MDR
//   req_ready_o     sequencer idle, request accepted on req_valid_i & req_ready_o
//   mar_q_i         address from MAR
//   mdr_q_i         write data from MDR
//   mem             memory bus (master side)
//   rd_data_o       registered read data, feeds MDR/IR input
//   mdr_load_o      one-cycle MDR load strobe
//   ir_load_o       one-cycle IR load strobe
//   done_o          one-cycle completion pulse
//   err_o           sticky timeout flag, cleared on the next accepted request
module mem_bus_sequencer #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  input  logic                      req_we_i,
  input  logic                      req_is_fetch_i,
  output logic                      req_ready_o,
  input  logic [AW-1:0]             mar_q_i,
  input  logic [DW-1:0]             mdr_q_i,
  mem_bus_sequencer_if.master       mem,
  output logic [DW-1:0]             rd_data_o,
  output logic                      mdr_load_o,
  output logic                      ir_load_o,
  output logic                      done_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          we_q, we_d;
  logic          tgt_q, tgt_d;
  logic          err_q, err_d;
  logic          resp_ok;

`ifdef MEM_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Timeout parameters only matter when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(TW'(TIMEOUT));
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      tgt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = mar_q_i;
          wdata_d = mdr_q_i;
          we_d    = req_we_i;
          tgt_d   = req_is_fetch_i;
          err_d   = 1'b0;
          state_d = StReq;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StReq: begin
        // mem_ready takes priority over the timeout on the same cycle.
        if (mem.mem_ready) begin
          if (!we_q) begin
            rdata_d = mem.mem_rdata;
          end
          state_d = StResp;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign req_ready_o   = (state_q == StIdle);
  assign mem.mem_valid = (state_q == StReq);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign rd_data_o     = rdata_q;
  assign done_o        = (state_q == StResp);

  // err_q is only ever set by a timeout of the current transaction (it is
  // cleared on accept), so it suppresses the load strobe of an aborted read.
  assign resp_ok    = done_o & ~we_q & ~err_q;
  assign ir_load_o  = resp_ok & tgt_q;
  assign mdr_load_o = resp_ok & ~tgt_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
module tb_mem_bus_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          req_is_fetch = 1'b0;
  logic          req_ready;
  logic [AW-1:0] mar_q = '0;
  logic [DW-1:0] mdr_q = '0;
  logic [DW-1:0] rd_data;
  logic          mdr_load, ir_load, done, err;

  int total = 0;
  int bad   = 0;

  mem_bus_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  mem_bus_sequencer #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO),
    .TW      (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_we_i       (req_we),
    .req_is_fetch_i (req_is_fetch),
    .req_ready_o    (req_ready),
    .mar_q_i        (mar_q),
    .mdr_q_i        (mdr_q),
    .mem            (bus),
    .rd_data_o      (rd_data),
    .mdr_load_o     (mdr_load),
    .ir_load_o      (ir_load),
    .done_o         (done),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access at a time, a completion
  // cycle after the handshake, and one dead cycle before the next accept.
  logic          m_busy, m_fin, m_we, m_tgt, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;
  int            m_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_fin <= 1'b0; m_we <= 1'b0; m_tgt <= 1'b0; m_err <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rd <= '0; m_wait <= 0;
    end else begin
      m_fin <= 1'b0;
      if (!m_busy && !m_fin && req_valid) begin
        m_busy <= 1'b1; m_addr <= mar_q; m_wdata <= mdr_q; m_we <= req_we;
        m_tgt <= req_is_fetch; m_err <= 1'b0; m_wait <= 0;
      end
      if (m_busy) begin
        if (bus.mem_ready) begin
          m_busy <= 1'b0; m_fin <= 1'b1;
          if (!m_we) m_rd <= bus.mem_rdata;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (m_wait == int'(TO)) begin
            m_busy <= 1'b0; m_fin <= 1'b1; m_err <= 1'b1;
          end
`endif
          m_wait <= m_wait + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_fin));
      chk("mem_valid", 32'(bus.mem_valid), 32'(m_busy));
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("done", 32'(done), 32'(m_fin));
      chk("ir_load", 32'(ir_load), 32'(m_fin && !m_we && m_tgt && !m_err));
      chk("mdr_load", 32'(mdr_load), 32'(m_fin && !m_we && !m_tgt && !m_err));
      chk("rd_data", rd_data, m_rd);
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_xfer;
  int n_wait;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Fetch, memory ready on the first REQ cycle.
    mar_q = 32'h100; req_we = 1'b0; req_is_fetch = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("fetch_valid", 32'(bus.mem_valid), 32'd1);
    chk("fetch_addr", bus.mem_addr, 32'h100);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
    step();
    bus.mem_ready = 1'b0;
    chk("fetch_done", 32'(done), 32'd1);
    chk("fetch_ir_load", 32'(ir_load), 32'd1);
    chk("fetch_mdr_load", 32'(mdr_load), 32'd0);
    chk("fetch_rd_data", rd_data, 32'h00500093);
    step();
    chk("fetch_done_clr", 32'(done), 32'd0);

    // Load with three wait states.
    mar_q = 32'h200; req_is_fetch = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("load_wait_valid", 32'(bus.mem_valid), 32'd1);
      chk("load_wait_addr", bus.mem_addr, 32'h200);
      chk("load_wait_done", 32'(done), 32'd0);
      step();
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
    chk("load_done", 32'(done), 32'd1);
    chk("load_mdr_load", 32'(mdr_load), 32'd1);
    chk("load_ir_load", 32'(ir_load), 32'd0);
    chk("load_rd_data", rd_data, 32'hDEADBEEF);
    step();

    // Write: no load strobe, rd_data untouched.
    mar_q = 32'h2000; mdr_q = 32'hCAFEF00D; req_we = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("wr_we", 32'(bus.mem_we), 32'd1);
    chk("wr_wdata", bus.mem_wdata, 32'hCAFEF00D);
    chk("wr_addr", bus.mem_addr, 32'h2000);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    step();
    bus.mem_ready = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_no_load", 32'({ir_load, mdr_load}), 32'd0);
    chk("wr_rd_data", rd_data, 32'hDEADBEEF);
    step();

    // Back-to-back: req_valid and mem_ready held high.
    req_we = 1'b0; req_is_fetch = 1'b1; mar_q = 32'h300;
    bus.mem_rdata = 32'h0000ABCD; req_valid = 1'b1; bus.mem_ready = 1'b1;
    n_xfer = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.mem_valid && bus.mem_ready) n_xfer++;
    end
    chk("b2b_xfers", 32'(n_xfer), 32'd4);
    req_valid = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) step();

`ifdef MEM_TIMEOUT_EN
    // Timeout: memory never ready.
    mar_q = 32'h400; req_is_fetch = 1'b0; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_wait = 0;
    while (!done && n_wait < 20) begin
      step();
      n_wait++;
    end
    chk("to_cycles", 32'(n_wait), 32'd5);
    chk("to_err", 32'(err), 32'd1);
    chk("to_no_load", 32'({ir_load, mdr_load}), 32'd0);
    chk("to_rd_data", rd_data, 32'h0000ABCD);
    step();
    chk("to_err_sticky", 32'(err), 32'd1);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("to_err_clr", 32'(err), 32'd0);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    step();
`else
    n_wait = 0;
`endif

    // Reset in the middle of a REQ.
    mar_q = 32'h500; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_valid_pre", 32'(bus.mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid", 32'(bus.mem_valid), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_loads", 32'({ir_load, mdr_load}), 32'd0);
    chk("mid_rd_data", rd_data, 32'd0);
    step();
    rst = 1'b0;
    repeat (2) step();
    chk("post_rst_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
